// File: rtl/sudoku_pkg.sv
// Shared constants, widths and FSM encoding for the Sudoku cursor controller.
package sudoku_pkg;

  localparam int GRID_N     = 9;
  localparam int MAX_DIGIT  = 9;
  localparam int VAL_W      = 4;
  localparam int POS_W      = 4;

  localparam logic [VAL_W-1:0] EMPTY_CELL = 4'd0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up/down counter that wraps in both directions.
module wrap_counter #(
  parameter int MOD = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dn,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP_V = W'(MOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: hold, step down with wrap to TOP_V, or step up with wrap to 0.
  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = count_q;
    end else if (dn) begin
      if (count_q == {W{1'b0}}) begin
        count_d = TOP_V;
      end else begin
        count_d = count_q - {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      if (count_q == TOP_V) begin
        count_d = {W{1'b0}};
      end else begin
        count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sudoku_cursor_ctrl.sv
// Cursor movement and cell-edit controller for the 9x9 Sudoku board.
// One action per idle cycle (clr > inc > up > down > left > right); an edit on
// an unlocked cell raises wr_req and holds it until storage acknowledges.
module sudoku_cursor_ctrl
  import sudoku_pkg::*;
#(
  parameter int GRID_N    = sudoku_pkg::GRID_N,
  parameter int MAX_DIGIT = sudoku_pkg::MAX_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_inc,
  input  logic             btn_clr,
  input  logic [VAL_W-1:0] rd_value,
  input  logic             rd_given,
  output logic [POS_W-1:0] cur_row,
  output logic [POS_W-1:0] cur_col,
  output logic             wr_req,
  output logic [POS_W-1:0] wr_row,
  output logic [POS_W-1:0] wr_col,
  output logic [VAL_W-1:0] wr_value,
  input  logic             wr_ack,
  output logic             locked_hit
);

  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_DIGIT);
  localparam logic [VAL_W-1:0] ONE_V = 4'd1;

  state_e           state_q, state_d;
  logic             wr_req_q, wr_req_d;
  logic [POS_W-1:0] wr_row_q, wr_row_d;
  logic [POS_W-1:0] wr_col_q, wr_col_d;
  logic [VAL_W-1:0] wr_value_q, wr_value_d;
  logic             locked_hit_q, locked_hit_d;

  logic             act_clr, act_inc, act_up, act_down, act_left, act_right;
  logic             act_edit;
  logic [VAL_W-1:0] inc_value;

  // Single-winner priority decode; nothing is accepted outside IDLE.
  always_comb begin
    act_clr   = 1'b0;
    act_inc   = 1'b0;
    act_up    = 1'b0;
    act_down  = 1'b0;
    act_left  = 1'b0;
    act_right = 1'b0;
    if (state_q != ST_IDLE) begin
      act_clr = 1'b0;
    end else if (btn_clr) begin
      act_clr = 1'b1;
    end else if (btn_inc) begin
      act_inc = 1'b1;
    end else if (btn_up) begin
      act_up = 1'b1;
    end else if (btn_down) begin
      act_down = 1'b1;
    end else if (btn_left) begin
      act_left = 1'b1;
    end else if (btn_right) begin
      act_right = 1'b1;
    end else begin
      act_clr = 1'b0;
    end
  end

  assign act_edit = act_clr | act_inc;

  // Digit advance: MAX wraps to empty, out-of-range values count as empty.
  always_comb begin
    inc_value = EMPTY_CELL;
    if (rd_value == MAX_V) begin
      inc_value = EMPTY_CELL;
    end else if (rd_value > MAX_V) begin
      inc_value = ONE_V;
    end else begin
      inc_value = rd_value + ONE_V;
    end
  end

  wrap_counter #(.MOD(GRID_N), .W(POS_W)) u_row_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (act_up | act_down),
    .dn    (act_up),
    .count (cur_row)
  );

  wrap_counter #(.MOD(GRID_N), .W(POS_W)) u_col_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (act_left | act_right),
    .dn    (act_left),
    .count (cur_col)
  );

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    wr_req_d     = wr_req_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_value_d   = wr_value_q;
    locked_hit_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!act_edit) begin
          state_d = ST_IDLE;
        end else if (rd_given) begin
          locked_hit_d = 1'b1;
        end else begin
          state_d    = ST_WRITE;
          wr_req_d   = 1'b1;
          wr_row_d   = cur_row;
          wr_col_d   = cur_col;
          wr_value_d = act_clr ? EMPTY_CELL : inc_value;
        end
      end
      ST_WRITE: begin
        if (wr_ack) begin
          state_d  = ST_IDLE;
          wr_req_d = 1'b0;
        end else begin
          state_d  = ST_WRITE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset abandons any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_req_q     <= 1'b0;
      wr_row_q     <= 4'd0;
      wr_col_q     <= 4'd0;
      wr_value_q   <= 4'd0;
      locked_hit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_req_q     <= wr_req_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_value_q   <= wr_value_d;
      locked_hit_q <= locked_hit_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_value   = wr_value_q;
  assign locked_hit = locked_hit_q;

endmodule
